// File: rtl/voxel_gpu_sequencer.sv
// rtl/voxel_gpu_sequencer.sv - strip-by-strip command sequencer for the voxel GPU register slave
module voxel_gpu_sequencer #(
    parameter int H_RESOLUTION = 320,
    parameter int V_RESOLUTION = 240,
    parameter int NUM_SHADERS  = H_RESOLUTION,
    parameter int COL_BITS     = $clog2(H_RESOLUTION),
    parameter int ROW_BITS     = $clog2(V_RESOLUTION)
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [2:0]  s1_address,
    input  logic        s1_read,
    input  logic        s1_write,
    input  logic [31:0] s1_writedata,
    output logic [31:0] s1_readdata,
    output logic        s1_waitrequest,
    output logic        irq,
    output logic [7:0]  g_address,
    output logic        g_read,
    output logic        g_write,
    output logic [31:0] g_writedata,
    input  logic [31:0] g_readdata,
    input  logic        g_waitrequest,
    input  logic        gpu_irq,
    output logic [31:0] m_address,
    output logic        m_read,
    input  logic [31:0] m_readdata,
    input  logic        m_readdatavalid,
    input  logic        m_waitrequest
);

    localparam int                  TOTAL_PIXELS = H_RESOLUTION * V_RESOLUTION;
    localparam logic [COL_BITS-1:0] COL_LAST     = COL_BITS'(H_RESOLUTION - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_STRIP, S_VOXEL_FETCH, S_VOXEL_ISSUE, S_PAL_FETCH, S_PAL_ISSUE,
        S_PIXEL, S_GPU_WAIT, S_GPU_ACK, S_DONE, S_ERROR
    } state_t;

    state_t              state_q, state_d, ret_q, ret_d;
    logic                busy_q, busy_d, done_q, done_d, error_q, error_d;
    logic [31:0]         voxel_base_q, voxel_base_d, palette_base_q, palette_base_d;
    logic [31:0]         fb_base_q, fb_base_d;
    logic [15:0]         voxel_count_q, voxel_count_d, palette_count_q, palette_count_d;
    logic [15:0]         vox_n_q, vox_n_d, pal_n_q, pal_n_d, idx_q, idx_d;
    logic                req_done_q, req_done_d;
    logic [31:0]         word_q, word_d, strip_base_q, strip_base_d, pix_n_q, pix_n_d;
    logic [ROW_BITS-1:0] row_q, row_d;
    logic [COL_BITS-1:0] col_q, col_d;

    logic        pal_phase, status_rd, ctrl_wr;
    logic [15:0] cur_cnt;
    logic [31:0] cur_base, pixel_word;

    assign s1_waitrequest = 1'b0;
    assign irq            = done_q | error_q;
    assign pal_phase      = (state_q == S_PAL_FETCH) || (state_q == S_PAL_ISSUE);
    assign cur_cnt        = pal_phase ? pal_n_q : vox_n_q;
    assign cur_base       = pal_phase ? palette_base_q : voxel_base_q;
    assign status_rd      = s1_read && (s1_address == 3'd1);
    assign ctrl_wr        = s1_write && (s1_address == 3'd0);
    // Row and column are OR-ed into the framebuffer base, never added.
    assign pixel_word     = fb_base_q | (32'(row_q) << (COL_BITS + 1)) | (32'(col_q) << 1);

    always_comb begin
        s1_readdata = 32'd0;
        case (s1_address)
            3'd1:    s1_readdata = {29'd0, error_q, done_q, busy_q};
            3'd2:    s1_readdata = voxel_base_q;
            3'd3:    s1_readdata = {16'd0, voxel_count_q};
            3'd4:    s1_readdata = palette_base_q;
            3'd5:    s1_readdata = {16'd0, palette_count_q};
            3'd6:    s1_readdata = fb_base_q;
            default: s1_readdata = 32'd0;
        endcase
    end

    always_comb begin
        state_d         = state_q;
        ret_d           = ret_q;
        busy_d          = busy_q;
        done_d          = done_q && !status_rd;
        error_d         = error_q && !status_rd;
        voxel_base_d    = voxel_base_q;
        voxel_count_d   = voxel_count_q;
        palette_base_d  = palette_base_q;
        palette_count_d = palette_count_q;
        fb_base_d       = fb_base_q;
        vox_n_d         = vox_n_q;
        pal_n_d         = pal_n_q;
        idx_d           = idx_q;
        req_done_d      = req_done_q;
        word_d          = word_q;
        strip_base_d    = strip_base_q;
        pix_n_d         = pix_n_q;
        row_d           = row_q;
        col_d           = col_q;
        g_address       = 8'd0;
        g_read          = 1'b0;
        g_write         = 1'b0;
        g_writedata     = 32'd0;
        m_address       = 32'd0;
        m_read          = 1'b0;

        case (state_q)
            S_STRIP: begin
                g_write     = 1'b1;
                g_address   = 8'h03;
                g_writedata = strip_base_q;
                if (!g_waitrequest) begin
                    ret_d   = S_VOXEL_FETCH;
                    state_d = S_GPU_WAIT;
                end
            end
            S_VOXEL_FETCH, S_PAL_FETCH: begin
                if (cur_cnt == 16'd0) begin
                    state_d = pal_phase ? S_PIXEL : S_PAL_FETCH;
                end else if (!req_done_q) begin
                    m_read    = 1'b1;
                    m_address = cur_base + (32'(idx_q) << 2);
                    if (!m_waitrequest) req_done_d = 1'b1;
                end else if (m_readdatavalid) begin
                    word_d     = m_readdata;
                    req_done_d = 1'b0;
                    state_d    = pal_phase ? S_PAL_ISSUE : S_VOXEL_ISSUE;
                end
            end
            S_VOXEL_ISSUE, S_PAL_ISSUE: begin
                g_write     = 1'b1;
                g_address   = pal_phase ? 8'h01 : 8'h00;
                g_writedata = word_q;
                if (!g_waitrequest) begin
                    state_d = S_GPU_WAIT;
                    if (idx_q == cur_cnt - 16'd1) begin
                        idx_d = 16'd0;
                        ret_d = pal_phase ? S_PIXEL : S_PAL_FETCH;
                    end else begin
                        idx_d = idx_q + 16'd1;
                        ret_d = pal_phase ? S_PAL_FETCH : S_VOXEL_FETCH;
                    end
                end
            end
            S_PIXEL: begin
                g_write     = 1'b1;
                g_address   = 8'h02;
                g_writedata = pixel_word;
                if (!g_waitrequest) begin
                    state_d = S_GPU_WAIT;
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                    if (pix_n_q == 32'(NUM_SHADERS - 1)) begin
                        pix_n_d = 32'd0;
                        if (strip_base_q + 32'(NUM_SHADERS) == 32'(TOTAL_PIXELS)) begin
                            ret_d = S_DONE;
                        end else begin
                            strip_base_d = strip_base_q + 32'(NUM_SHADERS);
                            ret_d        = S_STRIP;
                        end
                    end else begin
                        pix_n_d = pix_n_q + 32'd1;
                        ret_d   = S_PIXEL;
                    end
                end
            end
            S_GPU_WAIT: begin
                if (gpu_irq) state_d = S_GPU_ACK;
            end
            S_GPU_ACK: begin
                g_read    = 1'b1;
                g_address = 8'h0f;
                if (!g_waitrequest) state_d = (g_readdata == 32'd0) ? ret_q : S_ERROR;
            end
            S_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            S_ERROR: begin
                error_d     = 1'b1;
                busy_d      = 1'b0;
                g_write     = 1'b1;
                g_address   = 8'h0f;
                g_writedata = 32'd1;
                if (!g_waitrequest) state_d = S_IDLE;
            end
            default: ;
        endcase

        if (s1_write) begin
            case (s1_address)
                3'd2:    voxel_base_d    = s1_writedata;
                3'd3:    voxel_count_d   = s1_writedata[15:0];
                3'd4:    palette_base_d  = s1_writedata;
                3'd5:    palette_count_d = s1_writedata[15:0];
                3'd6:    fb_base_d       = s1_writedata;
                default: ;
            endcase
        end

        // Abort overrides whatever the GPU or memory did this cycle.
        if (ctrl_wr && s1_writedata[1]) begin
            state_d    = S_IDLE;
            busy_d     = 1'b0;
            req_done_d = 1'b0;
            done_d     = done_q && !status_rd;
            error_d    = error_q && !status_rd;
        end else if (ctrl_wr && s1_writedata[0] && state_q == S_IDLE) begin
            state_d      = S_STRIP;
            busy_d       = 1'b1;
            vox_n_d      = voxel_count_q;
            pal_n_d      = palette_count_q;
            idx_d        = 16'd0;
            req_done_d   = 1'b0;
            strip_base_d = 32'd0;
            pix_n_d      = 32'd0;
            row_d        = '0;
            col_d        = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= S_IDLE;
            ret_q           <= S_IDLE;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            error_q         <= 1'b0;
            voxel_base_q    <= 32'd0;
            voxel_count_q   <= 16'd0;
            palette_base_q  <= 32'd0;
            palette_count_q <= 16'd0;
            fb_base_q       <= 32'd0;
            vox_n_q         <= 16'd0;
            pal_n_q         <= 16'd0;
            idx_q           <= 16'd0;
            req_done_q      <= 1'b0;
            word_q          <= 32'd0;
            strip_base_q    <= 32'd0;
            pix_n_q         <= 32'd0;
            row_q           <= '0;
            col_q           <= '0;
        end else begin
            state_q         <= state_d;
            ret_q           <= ret_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            error_q         <= error_d;
            voxel_base_q    <= voxel_base_d;
            voxel_count_q   <= voxel_count_d;
            palette_base_q  <= palette_base_d;
            palette_count_q <= palette_count_d;
            fb_base_q       <= fb_base_d;
            vox_n_q         <= vox_n_d;
            pal_n_q         <= pal_n_d;
            idx_q           <= idx_d;
            req_done_q      <= req_done_d;
            word_q          <= word_d;
            strip_base_q    <= strip_base_d;
            pix_n_q         <= pix_n_d;
            row_q           <= row_d;
            col_q           <= col_d;
        end
    end

endmodule

// File: tb/tb_voxel_gpu_sequencer.sv
// tb/tb_voxel_gpu_sequencer.sv - directed bench for voxel_gpu_sequencer with GPU and memory models
module tb_voxel_gpu_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic [2:0]  s1_address;
    logic        s1_read, s1_write;
    logic [31:0] s1_writedata, s1_readdata;
    logic        s1_waitrequest, irq;
    logic [7:0]  g_address;
    logic        g_read, g_write;
    logic [31:0] g_writedata, g_readdata;
    logic        g_waitrequest, gpu_irq;
    logic [31:0] m_address, m_readdata;
    logic        m_read, m_readdatavalid, m_waitrequest;

    int n_assert = 0;
    int n_fail   = 0;

    logic bp_en     = 1'b0;
    int   lat       = 1;
    int   err_at    = 0;
    logic clr_model = 1'b0;

    voxel_gpu_sequencer #(.H_RESOLUTION(4), .V_RESOLUTION(2), .NUM_SHADERS(4)) dut (
        .clock(clock), .reset(reset),
        .s1_address(s1_address), .s1_read(s1_read), .s1_write(s1_write),
        .s1_writedata(s1_writedata), .s1_readdata(s1_readdata), .s1_waitrequest(s1_waitrequest),
        .irq(irq),
        .g_address(g_address), .g_read(g_read), .g_write(g_write), .g_writedata(g_writedata),
        .g_readdata(g_readdata), .g_waitrequest(g_waitrequest), .gpu_irq(gpu_irq),
        .m_address(m_address), .m_read(m_read), .m_readdata(m_readdata),
        .m_readdatavalid(m_readdatavalid), .m_waitrequest(m_waitrequest)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // GPU slave model: irq 3 cycles after each command, cleared by a status read or a new command.
    int          gstall = 0, gcnt = 0, ack_n = 0, irq_rises = 0;
    logic        girq = 1'b0, irq_prev = 1'b0;
    logic [39:0] wq[$];

    assign g_waitrequest = bp_en && (g_write || g_read) && (gstall < 5);
    assign gpu_irq       = girq;
    assign g_readdata    = (g_read && (ack_n + 1 == err_at)) ? 32'd2 : 32'd0;

    always @(posedge clock) begin
        gstall <= ((g_write || g_read) && g_waitrequest) ? gstall + 1 : 0;
        if (clr_model || reset) begin
            wq.delete();
            gcnt      <= 0;
            girq      <= 1'b0;
            ack_n     <= 0;
            irq_rises <= 0;
            irq_prev  <= 1'b0;
        end else begin
            irq_prev <= irq;
            if (irq && !irq_prev) irq_rises <= irq_rises + 1;
            if (g_write && !g_waitrequest) begin
                wq.push_back({g_address, g_writedata});
                girq <= 1'b0;
                gcnt <= (g_address == 8'h0f) ? 0 : 3;
            end else if (gcnt > 0) begin
                gcnt <= gcnt - 1;
                if (gcnt == 1) girq <= 1'b1;
            end
            if (g_read && !g_waitrequest) begin
                girq  <= 1'b0;
                ack_n <= ack_n + 1;
            end
        end
    end

    int          mstall = 0, pend = 0, mrd_n = 0;
    logic        rdv = 1'b0;
    logic [31:0] pdata = '0, m_rdata_r = '0;

    assign m_waitrequest   = bp_en && m_read && (mstall < 5);
    assign m_readdatavalid = rdv;
    assign m_readdata      = m_rdata_r;

    always @(posedge clock) begin
        mstall <= (m_read && m_waitrequest) ? mstall + 1 : 0;
        rdv    <= 1'b0;
        if (m_read && !m_waitrequest) begin
            pend  <= lat;
            pdata <= mem_word(m_address);
        end else if (pend > 0) begin
            pend <= pend - 1;
            if (pend == 1) begin
                rdv       <= 1'b1;
                m_rdata_r <= pdata;
            end
        end
        if (clr_model) mrd_n <= 0;
        else if (m_read && !m_waitrequest) mrd_n <= mrd_n + 1;
    end

    logic        g_prev_stall = 1'b0, m_prev_stall = 1'b0;
    logic [41:0] g_prev_val = '0;
    logic [32:0] m_prev_val = '0;

    always @(negedge clock) begin
        if (reset) begin
            g_prev_stall <= 1'b0;
            m_prev_stall <= 1'b0;
        end else begin
            if (g_prev_stall) chk("g_stall_hold", {g_write, g_read, g_address, g_writedata}, g_prev_val);
            if (m_prev_stall) chk("m_stall_hold", {m_read, m_address}, m_prev_val);
            g_prev_stall <= (g_write || g_read) && g_waitrequest;
            g_prev_val   <= {g_write, g_read, g_address, g_writedata};
            m_prev_stall <= m_read && m_waitrequest;
            m_prev_val   <= {m_read, m_address};
        end
    end

    task automatic cpu_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clock);
        s1_write = 1'b1; s1_address = a; s1_writedata = d;
        @(negedge clock);
        s1_write = 1'b0;
    endtask

    task automatic cpu_read(input logic [2:0] a, output logic [31:0] d);
        @(negedge clock);
        s1_read = 1'b1; s1_address = a;
        #1 d = s1_readdata;
        @(negedge clock);
        s1_read = 1'b0;
    endtask

    task automatic clear_model();
        @(negedge clock);
        clr_model = 1'b1;
        @(negedge clock);
        clr_model = 1'b0;
    endtask

    task automatic start_frame(input string tag);
        cpu_write(3'd0, 32'd1);
        chk({tag, "_start_cmd"}, {g_write, g_address, g_writedata}, {1'b1, 8'h03, 32'h0});
    endtask

    task automatic wait_irq(input string tag, input int max);
        int n = 0;
        while (irq !== 1'b1 && n < max) begin
            @(negedge clock);
            n++;
        end
        chk({tag, "_irq"}, irq, 1'b1);
    endtask

    logic [39:0] exp_q[$];

    task automatic build_frame(input int vc, input int pc);
        exp_q.delete();
        for (int s = 0; s < 2; s++) begin
            exp_q.push_back({8'h03, 32'(s * 4)});
            for (int j = 0; j < vc; j++) exp_q.push_back({8'h00, mem_word(32'h100 + 32'(4 * j))});
            for (int j = 0; j < pc; j++) exp_q.push_back({8'h01, mem_word(32'h200 + 32'(4 * j))});
            for (int p = 0; p < 4; p++) exp_q.push_back({8'h02, 32'h1000 + 32'(s * 8) + 32'(p * 2)});
        end
    endtask

    task automatic cmp_seq(input string tag);
        int n;
        chk({tag, "_len"}, 64'(wq.size()), 64'(exp_q.size()));
        n = (wq.size() < exp_q.size()) ? wq.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk($sformatf("%s_w%0d", tag, i), wq[i], exp_q[i]);
    endtask

    logic [31:0] rd;

    initial begin
        reset = 1'b1; s1_address = 3'd0; s1_read = 1'b0; s1_write = 1'b0; s1_writedata = 32'd0;
        repeat (3) @(negedge clock);
        chk("rst_outputs", {irq, g_read, g_write, g_address, g_writedata, m_read, m_address},
            {1'b0, 1'b0, 1'b0, 8'h0, 32'h0, 1'b0, 32'h0});
        reset = 1'b0;
        cpu_read(3'd1, rd); chk("rst_status", rd, 32'd0);
        cpu_read(3'd6, rd); chk("rst_fb_base", rd, 32'd0);

        cpu_write(3'd2, 32'h100);
        cpu_write(3'd3, 32'hFFFF_0001);
        cpu_write(3'd4, 32'h200);
        cpu_write(3'd5, 32'd1);
        cpu_write(3'd6, 32'h1000);
        cpu_read(3'd3, rd); chk("count_upper_zero", rd, 32'd1);

        clear_model();
        start_frame("min");
        wait_irq("min", 2000);
        build_frame(1, 1);
        cmp_seq("min");
        chk("min_mreads", 64'(mrd_n), 64'd4);
        cpu_read(3'd1, rd); chk("min_status", rd, 32'd2);
        chk("min_irq_clear", irq, 1'b0);

        cpu_write(3'd3, 32'd0);
        cpu_write(3'd5, 32'd0);
        clear_model();
        start_frame("zero");
        wait_irq("zero", 2000);
        build_frame(0, 0);
        cmp_seq("zero");
        chk("zero_no_mread", 64'(mrd_n), 64'd0);
        cpu_read(3'd1, rd); chk("zero_status", rd, 32'd2);

        cpu_write(3'd3, 32'd2);
        cpu_write(3'd5, 32'd1);
        err_at = 3;
        clear_model();
        start_frame("err");
        wait_irq("err", 2000);
        repeat (5) @(negedge clock);
        exp_q.delete();
        exp_q.push_back({8'h03, 32'h0});
        exp_q.push_back({8'h00, mem_word(32'h100)});
        exp_q.push_back({8'h00, mem_word(32'h104)});
        exp_q.push_back({8'h0f, 32'h1});
        cmp_seq("err");
        cpu_read(3'd1, rd); chk("err_status", rd, 32'd4);
        chk("err_irq_clear", irq, 1'b0);
        err_at = 0;

        cpu_write(3'd3, 32'd1);
        bp_en = 1'b1; lat = 7;
        clear_model();
        start_frame("bp");
        wait_irq("bp", 5000);
        build_frame(1, 1);
        cmp_seq("bp");
        cpu_read(3'd1, rd); chk("bp_status", rd, 32'd2);
        bp_en = 1'b0; lat = 1;

        clear_model();
        start_frame("abort");
        begin
            int n = 0;
            while (!(g_write && g_address == 8'h02) && n < 500) begin
                @(negedge clock);
                n++;
            end
            chk("abort_reach_pixel", {g_write, g_address}, {1'b1, 8'h02});
        end
        s1_write = 1'b1; s1_address = 3'd0; s1_writedata = 32'd2;
        @(negedge clock);
        s1_write = 1'b0;
        chk("abort_idle_outputs", {g_write, g_read, m_read, irq}, 4'b0000);
        cpu_read(3'd1, rd); chk("abort_not_busy", rd, 32'd0);
        repeat (20) @(negedge clock);
        chk("abort_no_irq", {irq, 32'(irq_rises)}, 33'd0);
        clear_model();
        start_frame("restart");
        wait_irq("restart", 2000);
        build_frame(1, 1);
        cmp_seq("restart");
        cpu_read(3'd1, rd); chk("restart_status", rd, 32'd2);

        clear_model();
        start_frame("busy");
        repeat (30) @(negedge clock);
        cpu_write(3'd0, 32'd1);
        wait_irq("busy", 2000);
        cmp_seq("busy");
        cpu_read(3'd1, rd); chk("busy_status", rd, 32'd2);
        repeat (50) @(negedge clock);
        chk("busy_single_irq", {irq, 32'(irq_rises)}, {1'b0, 32'd1});

        bp_en = 1'b1; lat = 7;
        clear_model();
        start_frame("rst");
        begin
            int n = 0;
            while (!m_read && n < 500) begin
                @(negedge clock);
                n++;
            end
            chk("rst_reach_fetch", m_read, 1'b1);
        end
        reset = 1'b1;
        s1_address = 3'd2;
        @(negedge clock);
        #1;
        chk("rst_mid_outputs", {irq, g_read, g_write, g_address, g_writedata, m_read, m_address},
            {1'b0, 1'b0, 1'b0, 8'h0, 32'h0, 1'b0, 32'h0});
        chk("rst_mid_csr", s1_readdata, 32'd0);
        reset = 1'b0;
        cpu_read(3'd1, rd); chk("rst_mid_status", rd, 32'd0);
        repeat (20) @(negedge clock);
        chk("rst_stays_idle", {g_write, g_read, m_read, irq}, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
